// File: rtl/td4_pkg.sv
// Shared TD4 definitions: default widths, the NOP opcode and the program-memory FSM states.
package td4_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 4;
  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StRun,
    StError
  } prog_mem_state_t;

endpackage

// File: rtl/prog_mem_store.sv
// Instruction store: 2**ADDR_W x DATA_W registers, async clear, one sync write port and one
// async read port.
module prog_mem_store
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem_ctrl.sv
// TD4 program-memory controller: reloads the store from a byte stream and gates CPU fetch.
// Define PROG_MEM_CHECKSUM_EN to append and verify a mod-256 checksum byte after each load.
module prog_mem_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              cpu_run,
  output logic              load_err
);

  prog_mem_state_t   state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              cpu_run_q;
  logic              accept;
  logic              last_byte;
  logic              store_we;
  logic [DATA_W-1:0] store_rdata;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              load_err_q;
`endif

  assign in_ready  = (state_q == StLoad) || (state_q == StCheck);
  // load_req wins over a coincident byte, which is dropped.
  assign accept    = in_valid && in_ready && !load_req;
  assign last_byte = (idx_q == {ADDR_W{1'b1}});
  assign store_we  = accept && (state_q == StLoad);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cpu_run_q  <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q      <= '0;
      load_err_q <= 1'b0;
`endif
    end else if (load_req) begin
      state_q    <= StLoad;
      idx_q      <= '0;
      cpu_run_q  <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q      <= '0;
      load_err_q <= 1'b0;
`endif
    end else if (accept) begin
      unique case (state_q)
        StLoad: begin
          idx_q <= idx_q + ADDR_W'(1);
`ifdef PROG_MEM_CHECKSUM_EN
          sum_q <= sum_q + in_data;
          if (last_byte) begin
            state_q <= StCheck;
          end
`else
          if (last_byte) begin
            state_q   <= StRun;
            cpu_run_q <= 1'b1;
          end
`endif
        end
`ifdef PROG_MEM_CHECKSUM_EN
        StCheck: begin
          if (in_data == sum_q) begin
            state_q   <= StRun;
            cpu_run_q <= 1'b1;
          end else begin
            state_q    <= StError;
            load_err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  prog_mem_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .clk    (clk),
    .n_reset(n_reset),
    .we     (store_we),
    .waddr  (idx_q),
    .wdata  (in_data),
    .raddr  (address),
    .rdata  (store_rdata)
  );

  // Anything short of a verified program reads back as NOP.
  assign data    = (state_q == StRun) ? store_rdata : DATA_W'(NOP_OPCODE);
  assign cpu_run = cpu_run_q;

`ifdef PROG_MEM_CHECKSUM_EN
  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Directed self-checking bench for prog_mem_ctrl; follows PROG_MEM_CHECKSUM_EN like the RTL.
module tb_prog_mem_ctrl;

  logic       clk;
  logic       n_reset;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] address;
  logic [7:0] data;
  logic       cpu_run;
  logic       load_err;

  int vectors;
  int miscompares;

  logic [7:0] prog_a [16];

  prog_mem_ctrl #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .load_req(load_req),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .address (address),
    .data    (data),
    .cpu_run (cpu_run),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #3;
    vectors++;
    if (in_ready !== 1'b0 || cpu_run !== 1'b0) begin
      $display("FAIL reset_held: in_ready=%b cpu_run=%b, want 0 0", in_ready, cpu_run);
      miscompares++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (cpu_run !== 1'b0 || load_err !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL reset_flags: cpu_run=%b load_err=%b in_ready=%b, want 0 0 0",
               cpu_run, load_err, in_ready);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== 8'h00) begin
        $display("FAIL reset_data[%0d]: got %h want 00", a, data);
        miscompares++;
      end
    end
  endtask

  task automatic test_good_load();
    pulse_load();
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL good_ready: in_ready=%b want 1", in_ready);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) send_byte(prog_a[i]);
`ifdef PROG_MEM_CHECKSUM_EN
    vectors++;
    if (cpu_run !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL good_check_state: cpu_run=%b in_ready=%b want 0 1", cpu_run, in_ready);
      miscompares++;
    end
    send_byte(8'h42);
`endif
    vectors++;
    if (cpu_run !== 1'b1 || load_err !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL good_run: cpu_run=%b load_err=%b in_ready=%b want 1 0 0",
               cpu_run, load_err, in_ready);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== prog_a[a]) begin
        $display("FAIL good_data[%0d]: got %h want %h", a, data, prog_a[a]);
        miscompares++;
      end
    end
    // Trailing bytes in RUN must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    address  = 4'd0;
    #1;
    vectors++;
    if (cpu_run !== 1'b1 || data !== 8'h70) begin
      $display("FAIL run_extra_byte: cpu_run=%b data=%h want 1 70", cpu_run, data);
      miscompares++;
    end
  endtask

  task automatic test_bad_checksum();
`ifdef PROG_MEM_CHECKSUM_EN
    pulse_load();
    for (int i = 0; i < 16; i++) send_byte(prog_a[i]);
    send_byte(8'h43);
    vectors++;
    if (load_err !== 1'b1 || cpu_run !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL bad_flags: load_err=%b cpu_run=%b in_ready=%b want 1 0 0",
               load_err, cpu_run, in_ready);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== 8'h00) begin
        $display("FAIL bad_data[%0d]: got %h want 00", a, data);
        miscompares++;
      end
    end
`else
    vectors++;
    if (load_err !== 1'b0) begin
      $display("FAIL err_tied: load_err=%b want 0", load_err);
      miscompares++;
    end
`endif
  endtask

  task automatic test_restart();
    pulse_load();
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    pulse_load();
    vectors++;
    if (in_ready !== 1'b1 || cpu_run !== 1'b0 || load_err !== 1'b0) begin
      $display("FAIL restart_flags: in_ready=%b cpu_run=%b load_err=%b want 1 0 0",
               in_ready, cpu_run, load_err);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) send_byte(8'hAA);
`ifdef PROG_MEM_CHECKSUM_EN
    send_byte(8'hA0);
`endif
    vectors++;
    if (cpu_run !== 1'b1) begin
      $display("FAIL restart_run: cpu_run=%b want 1", cpu_run);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== 8'hAA) begin
        $display("FAIL restart_data[%0d]: got %h want aa", a, data);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_pressure();
    pulse_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(prog_a[i]);
      @(posedge clk);
      #1;
    end
`ifdef PROG_MEM_CHECKSUM_EN
    send_byte(8'h42);
`endif
    vectors++;
    if (cpu_run !== 1'b1) begin
      $display("FAIL bp_run: cpu_run=%b want 1", cpu_run);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== prog_a[a]) begin
        $display("FAIL bp_data[%0d]: got %h want %h", a, data, prog_a[a]);
        miscompares++;
      end
    end
    // load_req coincident with an accepted byte: the byte must be dropped.
    pulse_load();
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(8'(i + 1));
    vectors++;
    if (cpu_run !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL drop_15: cpu_run=%b in_ready=%b want 0 1", cpu_run, in_ready);
      miscompares++;
    end
    send_byte(8'h10);
`ifdef PROG_MEM_CHECKSUM_EN
    send_byte(8'h88);
`endif
    vectors++;
    if (cpu_run !== 1'b1) begin
      $display("FAIL drop_run: cpu_run=%b want 1", cpu_run);
      miscompares++;
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      vectors++;
      if (data !== 8'(a + 1)) begin
        $display("FAIL drop_data[%0d]: got %h want %h", a, data, 8'(a + 1));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_load();
    for (int i = 0; i < 8; i++) send_byte(8'h33);
    n_reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || cpu_run !== 1'b0 || data !== 8'h00) begin
      $display("FAIL midrst_async: in_ready=%b cpu_run=%b data=%h want 0 0 00",
               in_ready, cpu_run, data);
      miscompares++;
    end
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || cpu_run !== 1'b0 || load_err !== 1'b0) begin
      $display("FAIL midrst_idle: in_ready=%b cpu_run=%b load_err=%b want 0 0 0",
               in_ready, cpu_run, load_err);
      miscompares++;
    end
    pulse_load();
    for (int i = 0; i < 16; i++) send_byte(prog_a[i]);
`ifdef PROG_MEM_CHECKSUM_EN
    send_byte(8'h42);
`endif
    vectors++;
    if (cpu_run !== 1'b1) begin
      $display("FAIL midrst_reload: cpu_run=%b want 1", cpu_run);
      miscompares++;
    end
    address = 4'd3;
    #1;
    vectors++;
    if (data !== 8'hF1) begin
      $display("FAIL midrst_data3: got %h want f1", data);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_reset     = 1'b0;
    load_req    = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    address     = 4'd0;
    for (int i = 0; i < 16; i++) prog_a[i] = 8'h00;
    prog_a[0] = 8'h70;
    prog_a[1] = 8'h90;
    prog_a[2] = 8'h51;
    prog_a[3] = 8'hF1;

    test_reset();
    test_good_load();
    test_bad_checksum();
    test_restart();
    test_back_pressure();
    test_reset_mid_load();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
